turf_acknack_merge: RTL and testbench
=====================================

Name: turf_acknack_merge

Overview:
- Sits directly downstream of the two acknack ports (ACK instance and NACK instance).
- Merges their 16-bit acknack streams into one command stream for the frame buffer.
- Tags each command with its source, drops disallowed or closed-event entries, and suppresses back-to-back duplicates.
- Registered output stage with round-robin fairness between ACK and NACK.

Parameters:
- ADDR_BITS, 12, width of the frame-buffer address field in tdata[0 +: ADDR_BITS]; max 13.
- DROP_DISALLOWED, 1, when 1 entries with tdata[15]=0 are consumed and not forwarded; when 0 they are forwarded.
- DEDUP, 1, when 1 an entry identical to the last forwarded command (same type, allow and addr) is consumed and not forwarded.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- event_open_i  in  1  event window open; when low, all inputs are drained and discarded.
- s_ack_tdata  in  16  ACK entry: [15] allow, [0 +: ADDR_BITS] addr, other bits ignored.
- s_ack_tvalid  in  1  ACK entry valid.
- s_ack_tready  out  1  ACK entry accepted.
- s_nack_tdata  in  16  NACK entry, same format as s_ack_tdata.
- s_nack_tvalid  in  1  NACK entry valid.
- s_nack_tready  out  1  NACK entry accepted.
- m_cmd_tdata  out  16  command: [15] allow, [14] type (0=ACK, 1=NACK), [13:ADDR_BITS] zero, [0 +: ADDR_BITS] addr.
- m_cmd_tvalid  out  1  command valid.
- m_cmd_tready  in  1  frame buffer accepts command.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - m_cmd_tvalid=0, m_cmd_tdata=0.
  - last_grant=NACK, so ACK wins the first tie.
  - Dedup history invalid.
  - A command held in the output register is discarded.
- While aresetn=0: s_ack_tready=0 and s_nack_tready=0.
- Output register is free when m_cmd_tvalid=0, or when m_cmd_tvalid=1 and m_cmd_tready=1 in the same cycle.
- Arbitration is combinational, using registered last_grant:
  - Only one input valid: that input is the candidate.
  - Both inputs valid: the candidate is the one not equal to last_grant.
- Each cycle the candidate is classified as one of:
  - DISCARD: event_open_i=0, or (DROP_DISALLOWED=1 and allow=0), or (DEDUP=1, history valid, and {type, allow, addr} equals history).
  - FORWARD: otherwise.
- DISCARD: the candidate's tready=1 regardless of output state. Nothing is loaded. last_grant updates to the candidate.
- FORWARD: the candidate's tready=1 only when the output register is free.
  - On the handshake the output register loads the command in the next cycle (1-cycle latency, input to m_cmd_tvalid).
  - last_grant updates and dedup history is written.
- The non-candidate input's tready=0 always. At most one input handshake per cycle.
- While the output is stalled, m_cmd_tdata and m_cmd_tvalid hold stable. m_cmd_tvalid never deasserts without a handshake, except on reset.
- Full throughput: back-to-back FORWARDs give one command per cycle when m_cmd_tready=1.
- event_open_i falling edge:
  - Dedup history is invalidated on the next edge.
  - A command already in the output register is still delivered.
- Dedup history is also invalidated whenever event_open_i=0.
- Simultaneous output handshake and new load: the new command replaces the old one with no bubble.

Optional Feature:
- Macro: TURF_ACKNACK_MERGE_STATS_EN.
- When defined, adds outputs:
  - ack_count_o (32): forwarded ACKs.
  - nack_count_o (32): forwarded NACKs.
  - drop_count_o (32): discards.
  - stats_clear_i (in, 1).
- Counter rules:
  - Counters wrap at 2^32.
  - Reset to 0 on aresetn=0 or stats_clear_i=1.
  - stats_clear_i takes precedence over a same-cycle increment.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- ACK 0x8005 alone, m_cmd_tready=1, open=1 -> m_cmd_tdata=0x8005 one cycle after handshake, tvalid for 1 cycle.
- ACK 0x8001 and NACK 0x8002 held valid continuously with distinct addrs each beat (ACK 0x8001,0x8003; NACK 0x8002,0x8004), ready=1 -> outputs 0x8001, 0xC002, 0x8003, 0xC004.
- m_cmd_tready=0 for 5 cycles with ACK 0x8010 pending -> first command held stable, s_ack_tready=0 for the second entry; release -> data unchanged, no loss.
- NACK 0x0007 (allow=0), DROP_DISALLOWED=1 -> s_nack_tready=1, no m_cmd_tvalid, drop_count +1.
- ACK 0x8020 sent twice consecutively, DEDUP=1 -> one output. Toggle event_open_i low then high, resend -> forwarded again.
- Reset asserted with m_cmd_tvalid=1 and ready=0 -> next cycle tvalid=0, both treadies 0; after release a tie goes to ACK first.

Source files
------------

// File: rtl/turf_acknack_merge.sv
// Purpose: merge ACK/NACK acknack streams into one tagged frame-buffer command stream (drop/dedup filtering).
// Latency: 1 cycle from input handshake to m_cmd_tvalid; round-robin between ACK and NACK on ties.
// Backpressure: a forwarded entry waits for a free output register; discarded entries always drain.
// Optional: define TURF_ACKNACK_MERGE_STATS_EN to add forwarded/dropped counters with stats_clear_i.
module turf_acknack_merge #(
  parameter int unsigned ADDR_BITS       = 12,   // at most 13: bit 14 carries the type tag
  parameter bit          DROP_DISALLOWED = 1'b1,
  parameter bit          DEDUP           = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        event_open_i,
  input  logic [15:0] s_ack_tdata,
  input  logic        s_ack_tvalid,
  output logic        s_ack_tready,
  input  logic [15:0] s_nack_tdata,
  input  logic        s_nack_tvalid,
  output logic        s_nack_tready,
  output logic [15:0] m_cmd_tdata,
  output logic        m_cmd_tvalid,
  input  logic        m_cmd_tready
`ifdef TURF_ACKNACK_MERGE_STATS_EN
  ,
  input  logic        stats_clear_i,
  output logic [31:0] ack_count_o,
  output logic [31:0] nack_count_o,
  output logic [31:0] drop_count_o
`endif
);

  // Source tag; its encoding is also the type bit placed in command bit 14.
  typedef enum logic {
    SRC_ACK  = 1'b0,
    SRC_NACK = 1'b1
  } src_e;

  // What dedup compares against: the identity of the last forwarded command.
  typedef struct packed {
    logic                 typ;
    logic                 allow;
    logic [ADDR_BITS-1:0] addr;
  } key_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  src_e        last_grant_q, last_grant_d;
  logic        hist_vld_q,   hist_vld_d;
  key_t        hist_q,       hist_d;
  logic        out_vld_q,    out_vld_d;
  logic [15:0] out_dat_q,    out_dat_d;

  // ---------------------------------------------------------------------------
  // Candidate selection and classification
  // ---------------------------------------------------------------------------
  src_e        cand_sel;
  logic        cand_vld;
  logic [15:0] cand_dat;
  key_t        cand_key;
  logic [15:0] cand_cmd;
  logic        cand_discard;
  logic        out_free;
  logic        accept;
  logic        load;
  logic        unused_cand_bits;

  // Bits between the address field and the allow bit carry no meaning on input.
  assign unused_cand_bits = ^cand_dat[14:ADDR_BITS];

  // Output register can take a new command if empty or being emptied this cycle.
  assign out_free = !out_vld_q || m_cmd_tready;

  // Round-robin pick: a lone valid input wins outright; a tie goes to whoever lost last.
  always_comb begin
    cand_vld = s_ack_tvalid || s_nack_tvalid;
    cand_sel = SRC_ACK;
    if (s_ack_tvalid && s_nack_tvalid) begin
      cand_sel = (last_grant_q == SRC_ACK) ? SRC_NACK : SRC_ACK;
    end else if (s_nack_tvalid) begin
      cand_sel = SRC_NACK;
    end
    cand_dat = (cand_sel == SRC_NACK) ? s_nack_tdata : s_ack_tdata;
  end

  // Build the outgoing command word and the dedup key from the chosen entry.
  always_comb begin
    cand_key.typ   = cand_sel;
    cand_key.allow = cand_dat[15];
    cand_key.addr  = cand_dat[ADDR_BITS-1:0];

    cand_cmd                  = '0;
    cand_cmd[15]              = cand_key.allow;
    cand_cmd[14]              = cand_key.typ;
    cand_cmd[ADDR_BITS-1:0]   = cand_key.addr;
  end

  // Decide whether the candidate is thrown away or must go out.
  always_comb begin
    cand_discard = 1'b0;
    if (!event_open_i) begin
      cand_discard = 1'b1;
    end else if (DROP_DISALLOWED && !cand_key.allow) begin
      cand_discard = 1'b1;
    end else if (DEDUP && hist_vld_q && (cand_key == hist_q)) begin
      cand_discard = 1'b1;
    end
  end

  // Discards drain unconditionally; forwards need room. Nothing moves under reset.
  assign accept = aresetn && cand_vld && (cand_discard || out_free);
  assign load   = accept && !cand_discard;

  assign s_ack_tready  = accept && (cand_sel == SRC_ACK);
  assign s_nack_tready = accept && (cand_sel == SRC_NACK);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Output register: load replaces (or follows) a draining command with no bubble.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_dat_d = cand_cmd;
    end else if (out_vld_q && m_cmd_tready) begin
      out_vld_d = 1'b0;
    end
  end

  // Arbitration memory follows whichever input actually handshook.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = cand_sel;
    end
  end

  // Dedup history remembers only forwarded commands and forgets when the event closes.
  always_comb begin
    hist_vld_d = hist_vld_q;
    hist_d     = hist_q;
    if (!event_open_i) begin
      hist_vld_d = 1'b0;
    end else if (load) begin
      hist_vld_d = 1'b1;
      hist_d     = cand_key;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Core state with synchronous reset; ACK wins the first tie after reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_grant_q <= SRC_NACK;
      hist_vld_q   <= 1'b0;
      hist_q       <= '0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hist_vld_q   <= hist_vld_d;
      hist_q       <= hist_d;
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
    end
  end

  assign m_cmd_tvalid = out_vld_q;
  assign m_cmd_tdata  = out_dat_q;

`ifdef TURF_ACKNACK_MERGE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [31:0] ack_count_q,  ack_count_d;
  logic [31:0] nack_count_q, nack_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // Free-running wrap-around counters; a clear beats any same-cycle increment.
  always_comb begin
    ack_count_d  = ack_count_q;
    nack_count_d = nack_count_q;
    drop_count_d = drop_count_q;
    if (stats_clear_i) begin
      ack_count_d  = '0;
      nack_count_d = '0;
      drop_count_d = '0;
    end else begin
      if (load && (cand_sel == SRC_ACK)) begin
        ack_count_d = ack_count_q + 32'd1;
      end
      if (load && (cand_sel == SRC_NACK)) begin
        nack_count_d = nack_count_q + 32'd1;
      end
      if (accept && cand_discard) begin
        drop_count_d = drop_count_q + 32'd1;
      end
    end
  end

  // Counter registers cleared by reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ack_count_q  <= '0;
      nack_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      ack_count_q  <= ack_count_d;
      nack_count_q <= nack_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign ack_count_o  = ack_count_q;
  assign nack_count_o = nack_count_q;
  assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_turf_acknack_merge.sv
// Bench for turf_acknack_merge: scoreboard of expected commands, drivers per input, output monitor.
// Inputs change just after the falling edge; outputs are sampled a little after the falling edge.
// Counter checks appear only when TURF_ACKNACK_MERGE_STATS_EN is defined.
module tb_turf_acknack_merge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        event_open_i;
  logic [15:0] s_ack_tdata;
  logic        s_ack_tvalid;
  logic        s_ack_tready;
  logic [15:0] s_nack_tdata;
  logic        s_nack_tvalid;
  logic        s_nack_tready;
  logic [15:0] m_cmd_tdata;
  logic        m_cmd_tvalid;
  logic        m_cmd_tready;
`ifdef TURF_ACKNACK_MERGE_STATS_EN
  logic        stats_clear_i;
  logic [31:0] ack_count_o;
  logic [31:0] nack_count_o;
  logic [31:0] drop_count_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [15:0] sb_q[$];

  always #5 aclk = ~aclk;

  turf_acknack_merge dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .event_open_i  (event_open_i),
    .s_ack_tdata   (s_ack_tdata),
    .s_ack_tvalid  (s_ack_tvalid),
    .s_ack_tready  (s_ack_tready),
    .s_nack_tdata  (s_nack_tdata),
    .s_nack_tvalid (s_nack_tvalid),
    .s_nack_tready (s_nack_tready),
    .m_cmd_tdata   (m_cmd_tdata),
    .m_cmd_tvalid  (m_cmd_tvalid),
    .m_cmd_tready  (m_cmd_tready)
`ifdef TURF_ACKNACK_MERGE_STATS_EN
    ,
    .stats_clear_i (stats_clear_i),
    .ack_count_o   (ack_count_o),
    .nack_count_o  (nack_count_o),
    .drop_count_o  (drop_count_o)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one ACK entry until accepted (bounded); called at a falling edge, returns at one.
  task automatic send_ack(input logic [15:0] d);
    logic rdy;
    int   cyc;
    s_ack_tdata  = d;
    s_ack_tvalid = 1'b1;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      #1;
      rdy = s_ack_tready;
      @(negedge aclk);
      cyc++;
    end
    s_ack_tvalid = 1'b0;
    chk("ack_handshake", {31'd0, rdy}, 32'd1);
  endtask

  // Same as send_ack for the NACK input.
  task automatic send_nack(input logic [15:0] d);
    logic rdy;
    int   cyc;
    s_nack_tdata  = d;
    s_nack_tvalid = 1'b1;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      #1;
      rdy = s_nack_tready;
      @(negedge aclk);
      cyc++;
    end
    s_nack_tvalid = 1'b0;
    chk("nack_handshake", {31'd0, rdy}, 32'd1);
  endtask

  // Output monitor: every command handshake must match the oldest expected entry.
  always begin
    logic [15:0] exp;
    @(negedge aclk);
    #2;
    if (aresetn === 1'b1 && m_cmd_tvalid === 1'b1 && m_cmd_tready === 1'b1) begin
      chk("cmd_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("cmd_data", {16'd0, m_cmd_tdata}, {16'd0, exp});
      end
    end
  end

  initial begin
    aresetn       = 1'b0;
    event_open_i  = 1'b1;
    s_ack_tdata   = 16'h0;
    s_ack_tvalid  = 1'b1;
    s_nack_tdata  = 16'h0;
    s_nack_tvalid = 1'b1;
    m_cmd_tready  = 1'b1;
`ifdef TURF_ACKNACK_MERGE_STATS_EN
    stats_clear_i = 1'b0;
`endif

    // Reset state: no output, no input acceptance even with inputs valid.
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, m_cmd_tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, m_cmd_tdata}, 32'd0);
    chk("rst_ack_rdy", {31'd0, s_ack_tready}, 32'd0);
    chk("rst_nack_rdy", {31'd0, s_nack_tready}, 32'd0);
    @(negedge aclk);
    s_ack_tvalid  = 1'b0;
    s_nack_tvalid = 1'b0;
    aresetn       = 1'b1;
    @(negedge aclk);

    // Both inputs continuously valid: strict alternation starting with ACK.
    sb_q.push_back(16'h8001);
    sb_q.push_back(16'hC002);
    sb_q.push_back(16'h8003);
    sb_q.push_back(16'hC004);
    fork
      begin send_ack(16'h8001); send_ack(16'h8003); end
      begin send_nack(16'h8002); send_nack(16'h8004); end
    join
    repeat (2) @(negedge aclk);
    chk("rr_drained", sb_q.size(), 32'd0);

    // Lone ACK: visible one cycle after handshake, for exactly one cycle.
    sb_q.push_back(16'h8005);
    send_ack(16'h8005);
    chk("lat_tvalid", {31'd0, m_cmd_tvalid}, 32'd1);
    chk("lat_tdata", {16'd0, m_cmd_tdata}, 32'h8005);
    @(negedge aclk);
    chk("lat_one_beat", {31'd0, m_cmd_tvalid}, 32'd0);

    // Output stall: held command stays stable, second entry blocked, then both delivered.
    m_cmd_tready = 1'b0;
    sb_q.push_back(16'h8010);
    sb_q.push_back(16'h8011);
    send_ack(16'h8010);
    fork
      send_ack(16'h8011);
      begin
        for (int i = 0; i < 5; i++) begin
          #1;
          chk("stall_tvalid", {31'd0, m_cmd_tvalid}, 32'd1);
          chk("stall_tdata", {16'd0, m_cmd_tdata}, 32'h8010);
          chk("stall_ack_rdy", {31'd0, s_ack_tready}, 32'd0);
          @(negedge aclk);
        end
        m_cmd_tready = 1'b1;
      end
    join
    repeat (2) @(negedge aclk);
    chk("stall_drained", sb_q.size(), 32'd0);

`ifdef TURF_ACKNACK_MERGE_STATS_EN
    stats_clear_i = 1'b1;
    @(negedge aclk);
    stats_clear_i = 1'b0;
    chk("clr_ack_cnt", ack_count_o, 32'd0);
    chk("clr_drop_cnt", drop_count_o, 32'd0);
`endif

    // Disallowed NACK is consumed and never forwarded.
    send_nack(16'h0007);
    chk("disallow_no_out", {31'd0, m_cmd_tvalid}, 32'd0);
    @(negedge aclk);
    chk("disallow_no_out2", {31'd0, m_cmd_tvalid}, 32'd0);
`ifdef TURF_ACKNACK_MERGE_STATS_EN
    chk("disallow_drop_cnt", drop_count_o, 32'd1);
`endif

    // Duplicate suppressed; closing the event drains input and clears history.
    sb_q.push_back(16'h8020);
    send_ack(16'h8020);
    send_ack(16'h8020);
    repeat (3) @(negedge aclk);
    chk("dedup_drained", sb_q.size(), 32'd0);
    event_open_i = 1'b0;
    send_nack(16'h8030);
    @(negedge aclk);
    chk("closed_no_out", {31'd0, m_cmd_tvalid}, 32'd0);
    event_open_i = 1'b1;
    sb_q.push_back(16'h8020);
    send_ack(16'h8020);
    repeat (2) @(negedge aclk);
    chk("reopen_drained", sb_q.size(), 32'd0);
`ifdef TURF_ACKNACK_MERGE_STATS_EN
    chk("ack_cnt", ack_count_o, 32'd2);
    chk("nack_cnt", nack_count_o, 32'd0);
    chk("drop_cnt", drop_count_o, 32'd3);
`endif

    // Reset with a stalled command: it is discarded and a later tie goes to ACK.
    m_cmd_tready = 1'b0;
    send_ack(16'h8050);
    chk("prerst_tvalid", {31'd0, m_cmd_tvalid}, 32'd1);
    aresetn       = 1'b0;
    s_ack_tdata   = 16'h8041;
    s_ack_tvalid  = 1'b1;
    s_nack_tdata  = 16'h8042;
    s_nack_tvalid = 1'b1;
    #1;
    chk("inrst_ack_rdy", {31'd0, s_ack_tready}, 32'd0);
    chk("inrst_nack_rdy", {31'd0, s_nack_tready}, 32'd0);
    @(negedge aclk);
    chk("postrst_tvalid", {31'd0, m_cmd_tvalid}, 32'd0);
    chk("postrst_tdata", {16'd0, m_cmd_tdata}, 32'd0);
    chk("postrst_ack_rdy", {31'd0, s_ack_tready}, 32'd0);
`ifdef TURF_ACKNACK_MERGE_STATS_EN
    chk("postrst_drop_cnt", drop_count_o, 32'd0);
`endif
    aresetn      = 1'b1;
    m_cmd_tready = 1'b1;
    sb_q.push_back(16'h8041);
    sb_q.push_back(16'hC042);
    fork
      send_ack(16'h8041);
      send_nack(16'h8042);
    join
    repeat (3) @(negedge aclk);
    #3;
    chk("final_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
